// File: rtl/writeback_stage_pkg.sv
// Shared pipeline definitions for the execute/writeback boundary.
//   - alu_op_t   : ALU operation encodings used by the execute stage
//   - EX_WB      : EX->WB stage register contents
//   - wb_state_t : writeback load-arbitration FSM states
package writeback_stage_pkg;

  localparam int XLEN    = 32;
  localparam int NREGS   = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  // EX->WB pipeline register
  typedef struct packed {
    logic [XLEN-1:0]    alu_result;
    logic               alu_result_ready;
    logic [RADDR_W-1:0] reg_wr_addr;
    logic               rd_wr_en;
    logic               do_not_execute;
  } EX_WB;

  // IDLE: no pending load. HOLD: a load lost arbitration to the ALU and
  // is parked in the hold buffer until the write port is free.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_regfile_2r1w.sv
// regfile_2r1w: 32x32 register file, one write port, two combinational
// read ports with forwarding of values that commit at the next edge.
// Ports:
//   clk, reset                 clock, synchronous active-high clear
//   we/waddr/wdata             write port (commits at posedge)
//   byp_alu_*                  this cycle's ALU write (highest forward prio)
//   byp_hold_*                 occupied hold buffer
//   byp_ld_*                   this cycle's direct load commit
//   rs1_addr/rs2_addr          read addresses
//   rs1_data/rs2_data          read data (x0 always 0)
module regfile_2r1w
  import writeback_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]    wdata,
  input  logic               byp_alu_valid,
  input  logic [RADDR_W-1:0] byp_alu_addr,
  input  logic [XLEN-1:0]    byp_alu_data,
  input  logic               byp_hold_valid,
  input  logic [RADDR_W-1:0] byp_hold_addr,
  input  logic [XLEN-1:0]    byp_hold_data,
  input  logic               byp_ld_valid,
  input  logic [RADDR_W-1:0] byp_ld_addr,
  input  logic [XLEN-1:0]    byp_ld_data,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]    rs1_data,
  output logic [XLEN-1:0]    rs2_data
);

  // Built from flops rather than block RAM: every entry must clear on
  // reset and reads are zero latency.
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Two identical read ports; forwarding order reflects write age:
  // ALU (newest) beats the parked load, which beats a direct load.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [RADDR_W-1:0] addr;
    logic [XLEN-1:0]    data;

    assign addr = (gi == 0) ? rs1_addr : rs2_addr;

    always_comb begin
      data = mem_q[addr];
      if (addr == '0) begin
        data = '0;
      end else if (byp_alu_valid && (byp_alu_addr == addr)) begin
        data = byp_alu_data;
      end else if (byp_hold_valid && (byp_hold_addr == addr)) begin
        data = byp_hold_data;
      end else if (byp_ld_valid && (byp_ld_addr == addr)) begin
        data = byp_ld_data;
      end
    end
  end

  assign rs1_data = g_rd[0].data;
  assign rs2_data = g_rd[1].data;

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: arbitrates the single register-file write port between
// ALU results and load returns, parks a colliding load in a one-entry
// hold buffer, and counts committed writes.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   ex_wb_r                       EX->WB register (ALU result + control)
//   ld_valid/ld_addr/ld_data      load write request
//   ld_ready                      load accepted this cycle (= ~wb_busy)
//   rs1_addr/rs2_addr             operand read addresses
//   alu_reg_input_a/_b            forwarded operands to the ALU stage
//   wb_busy                       hold buffer occupied
//   retired_count                 committed register writes (wraps)
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  EX_WB               ex_wb_r,
  input  logic               ld_valid,
  input  logic [RADDR_W-1:0] ld_addr,
  input  logic [XLEN-1:0]    ld_data,
  output logic               ld_ready,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]    alu_reg_input_a,
  output logic [XLEN-1:0]    alu_reg_input_b,
  output logic               wb_busy,
  output logic [XLEN-1:0]    retired_count
);

  wb_state_t          state_q, state_d;
  logic [RADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [XLEN-1:0]    hold_data_q, hold_data_d;
  logic [XLEN-1:0]    retired_count_q, retired_count_d;

  logic               alu_wr;
  logic               ld_accept;
  logic               ld_live;
  logic               ld_direct;
  logic               drain;
  logic               wr_en;
  logic [RADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]    wr_data;

  assign wb_busy  = (state_q == HOLD);
  assign ld_ready = ~wb_busy;

  always_comb begin
    // Gated by reset so nothing is forwarded while state is being cleared.
    alu_wr    = ~reset & ex_wb_r.alu_result_ready & ex_wb_r.rd_wr_en &
                ~ex_wb_r.do_not_execute & (ex_wb_r.reg_wr_addr != '0);
    ld_accept = ld_valid & ld_ready;
    // Loads to x0 are accepted but have no effect.
    ld_live   = ld_accept & ~reset & (ld_addr != '0);

    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    ld_direct   = 1'b0;
    drain       = 1'b0;

    case (state_q)
      IDLE: begin
        if (ld_live) begin
          if (alu_wr) begin
            hold_addr_d = ld_addr;
            hold_data_d = ld_data;
            state_d     = HOLD;
          end else begin
            ld_direct = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!alu_wr) begin
          drain   = 1'b1;
          state_d = IDLE;
        end else if (ex_wb_r.reg_wr_addr == hold_addr_q) begin
          // The ALU result is younger than the parked load; drop the load.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // ALU always owns the port; the other two sources are exclusive with it.
    wr_en   = alu_wr | ld_direct | drain;
    wr_addr = hold_addr_q;
    wr_data = hold_data_q;
    if (alu_wr) begin
      wr_addr = ex_wb_r.reg_wr_addr;
      wr_data = ex_wb_r.alu_result;
    end else if (ld_direct) begin
      wr_addr = ld_addr;
      wr_data = ld_data;
    end

    retired_count_d = retired_count_q + {{(XLEN-1){1'b0}}, wr_en};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      hold_addr_q     <= '0;
      hold_data_q     <= '0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      hold_addr_q     <= hold_addr_d;
      hold_data_q     <= hold_data_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign retired_count = retired_count_q;

  regfile_2r1w u_regfile (
    .clk            (clk),
    .reset          (reset),
    .we             (wr_en),
    .waddr          (wr_addr),
    .wdata          (wr_data),
    .byp_alu_valid  (alu_wr),
    .byp_alu_addr   (ex_wb_r.reg_wr_addr),
    .byp_alu_data   (ex_wb_r.alu_result),
    .byp_hold_valid (wb_busy),
    .byp_hold_addr  (hold_addr_q),
    .byp_hold_data  (hold_data_q),
    .byp_ld_valid   (ld_direct),
    .byp_ld_addr    (ld_addr),
    .byp_ld_data    (ld_data),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_data       (alu_reg_input_a),
    .rs2_data       (alu_reg_input_b)
  );

endmodule
